// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard unit: forwarding encodings,
// scoreboard entry layout and the opcode classes used by the ID decoder.
package pipeline_hazard_unit_pkg;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    // Scoreboard rd is stored at a fixed width so the struct is parameter-free.
    localparam int SB_RD_W = 8;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               writes;
        logic               isLoad;
    } sb_entry_t;

    localparam logic [2:0] OPC_NOP    = 3'd0;
    localparam logic [2:0] OPC_ALU_RR = 3'd1;
    localparam logic [2:0] OPC_ALU_RI = 3'd2;
    localparam logic [2:0] OPC_LOAD   = 3'd3;
    localparam logic [2:0] OPC_STORE  = 3'd4;
    localparam logic [2:0] OPC_BRANCH = 3'd5;
    localparam logic [2:0] OPC_JUMP   = 3'd6;

    function automatic logic opcUsesRs1(input logic [2:0] opc);
        return (opc == OPC_ALU_RR) || (opc == OPC_ALU_RI) || (opc == OPC_LOAD) ||
               (opc == OPC_STORE)  || (opc == OPC_BRANCH);
    endfunction

    function automatic logic opcUsesRs2(input logic [2:0] opc);
        return (opc == OPC_ALU_RR) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    endfunction

    function automatic logic opcWritesRd(input logic [2:0] opc);
        return (opc == OPC_ALU_RR) || (opc == OPC_ALU_RI) || (opc == OPC_LOAD) ||
               (opc == OPC_JUMP);
    endfunction

    function automatic logic opcIsLoad(input logic [2:0] opc);
        return opc == OPC_LOAD;
    endfunction

endpackage

// File: rtl/pipeline_hazard_unit_sat_counter.sv
// Saturating event counter with asynchronous active-low clear; holds at all-ones.
module hazard_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard, stall and forwarding controller for a 5-stage pipeline; keeps a
// private EX/MEM/WB scoreboard of destination registers.
module pipeline_hazard_unit
    import pipeline_hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_uses_rs1_i,
    input  logic                  id_uses_rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_writes_rd_i,
    input  logic                  id_is_load_i,
    input  logic                  ex_jump_taken_i,
    output logic                  stall_o,
    output logic                  flush_if_id_o,
    output logic                  bubble_id_ex_o,
    output logic [1:0]            fwd_sel_a_o,
    output logic [1:0]            fwd_sel_b_o,
    output logic [1:0]            inflight_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    sb_entry_t sbEx_q, sbMem_q, sbWb_q;
    sb_entry_t sbEx_d;
    logic [1:0] fwdSelA_q, fwdSelB_q;
    logic [1:0] fwdSelA_d, fwdSelB_d;
    logic [SB_RD_W-1:0] rs1Ext, rs2Ext;
    logic hazard, idAdvance;

    assign rs1Ext = SB_RD_W'(id_rs1_i);
    assign rs2Ext = SB_RD_W'(id_rs2_i);

    assign hazard = id_valid_i && sbEx_q.valid && sbEx_q.writes && sbEx_q.isLoad &&
                    ((id_uses_rs1_i && (rs1Ext == sbEx_q.rd)) ||
                     (id_uses_rs2_i && (rs2Ext == sbEx_q.rd)));

    assign stall_o        = hazard && !ex_jump_taken_i;
    assign flush_if_id_o  = ex_jump_taken_i;
    assign bubble_id_ex_o = stall_o || ex_jump_taken_i;
    assign idAdvance      = id_valid_i && !stall_o && !ex_jump_taken_i;

    // The EX producer becomes EX_MEM and the MEM producer becomes MEM_WB by the
    // time the ID instruction reaches EX; a load in EX is handled by the stall.
    function automatic logic [1:0] fwdSelect(input logic uses, input logic [SB_RD_W-1:0] rs);
        if (uses && sbEx_q.valid && sbEx_q.writes && !sbEx_q.isLoad && (rs == sbEx_q.rd)) begin
            return FWD_EXMEM;
        end else if (uses && sbMem_q.valid && sbMem_q.writes && (rs == sbMem_q.rd)) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

    always_comb begin
        sbEx_d    = '0;
        fwdSelA_d = FWD_RF;
        fwdSelB_d = FWD_RF;
        if (idAdvance) begin
            sbEx_d.valid  = 1'b1;
            sbEx_d.rd     = SB_RD_W'(id_rd_i);
            sbEx_d.writes = id_writes_rd_i;
            sbEx_d.isLoad = id_is_load_i;
            fwdSelA_d     = fwdSelect(id_uses_rs1_i, rs1Ext);
            fwdSelB_d     = fwdSelect(id_uses_rs2_i, rs2Ext);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbEx_q    <= '0;
            sbMem_q   <= '0;
            sbWb_q    <= '0;
            fwdSelA_q <= FWD_RF;
            fwdSelB_q <= FWD_RF;
        end else begin
            sbEx_q    <= sbEx_d;
            sbMem_q   <= sbEx_q;
            sbWb_q    <= sbMem_q;
            fwdSelA_q <= fwdSelA_d;
            fwdSelB_q <= fwdSelB_d;
        end
    end

    assign fwd_sel_a_o = fwdSelA_q;
    assign fwd_sel_b_o = fwdSelB_q;
    assign inflight_o  = {1'b0, sbEx_q.valid} + {1'b0, sbMem_q.valid} + {1'b0, sbWb_q.valid};

    hazard_sat_counter #(.CNT_W(CNT_W)) uStallCnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (stall_o),
        .count_o (stall_cnt_o)
    );

    hazard_sat_counter #(.CNT_W(CNT_W)) uFlushCnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (ex_jump_taken_i),
        .count_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed self-checking bench for pipeline_hazard_unit with 4-bit counters.
module tb_pipeline_hazard_unit;
    import pipeline_hazard_unit_pkg::*;

    localparam int RW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          idValid;
    logic [RW-1:0] idRs1, idRs2, idRd;
    logic          idUsesRs1, idUsesRs2, idWritesRd, idIsLoad;
    logic          exJumpTaken;
    logic          stall, flushIfId, bubbleIdEx;
    logic [1:0]    fwdSelA, fwdSelB, inflight;
    logic [CW-1:0] stallCnt, flushCnt;

    int cmpCount = 0;
    int errCount = 0;

    pipeline_hazard_unit #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid_i      (idValid),
        .id_rs1_i        (idRs1),
        .id_rs2_i        (idRs2),
        .id_uses_rs1_i   (idUsesRs1),
        .id_uses_rs2_i   (idUsesRs2),
        .id_rd_i         (idRd),
        .id_writes_rd_i  (idWritesRd),
        .id_is_load_i    (idIsLoad),
        .ex_jump_taken_i (exJumpTaken),
        .stall_o         (stall),
        .flush_if_id_o   (flushIfId),
        .bubble_id_ex_o  (bubbleIdEx),
        .fwd_sel_a_o     (fwdSelA),
        .fwd_sel_b_o     (fwdSelB),
        .inflight_o      (inflight),
        .stall_cnt_o     (stallCnt),
        .flush_cnt_o     (flushCnt)
    );

    always #5 clk = ~clk;

    // Decode flags are derived from the opcode class, as the ID decoder would.
    task automatic applyStimulus(input logic v, input logic [2:0] opc, input int rd,
                                 input int rs1, input int rs2, input logic jmp);
        idValid     = v;
        idRd        = RW'(rd);
        idRs1       = RW'(rs1);
        idRs2       = RW'(rs2);
        idUsesRs1   = v && opcUsesRs1(opc);
        idUsesRs2   = v && opcUsesRs2(opc);
        idWritesRd  = v && opcWritesRd(opc);
        idIsLoad    = v && opcIsLoad(opc);
        exJumpTaken = jmp;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        cmpCount++;
        assert (observed === expected) else begin
            errCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, OPC_NOP, 0, 0, 0, 1'b0);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, OPC_NOP, 0, 0, 0, 1'b0);
        #12;
        checkOutput("rst_stall", 32'(stall), 0);
        checkOutput("rst_bubble", 32'(bubbleIdEx), 0);
        checkOutput("rst_inflight", 32'(inflight), 0);
        checkOutput("rst_stallcnt", 32'(stallCnt), 0);
        checkOutput("rst_flushcnt", 32'(flushCnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        checkOutput("idle_fwda", 32'(fwdSelA), 0);
        checkOutput("idle_fwdb", 32'(fwdSelB), 0);
        checkOutput("idle_inflight", 32'(inflight), 0);
        checkOutput("idle_flush", 32'(flushIfId), 0);

        $display("[TB] ALU chain");
        applyStimulus(1'b1, OPC_ALU_RR, 1, 2, 3, 1'b0);
        #1 checkOutput("alu1_stall", 32'(stall), 0);
        @(negedge clk);
        applyStimulus(1'b1, OPC_ALU_RR, 2, 1, 3, 1'b0);
        #1 checkOutput("alu2_stall", 32'(stall), 0);
        checkOutput("alu2_inflight", 32'(inflight), 1);
        @(negedge clk);
        applyStimulus(1'b0, OPC_NOP, 0, 0, 0, 1'b0);
        #1 checkOutput("alu2_fwda", 32'(fwdSelA), 1);
        checkOutput("alu2_fwdb", 32'(fwdSelB), 0);
        checkOutput("alu2_ex_inflight", 32'(inflight), 2);
        @(negedge clk);
        idle(3);

        $display("[TB] one-gap dependence");
        applyStimulus(1'b1, OPC_ALU_RR, 1, 2, 3, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, OPC_NOP, 0, 0, 0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, OPC_ALU_RR, 4, 1, 1, 1'b0);
        #1 checkOutput("gap_stall", 32'(stall), 0);
        @(negedge clk);
        applyStimulus(1'b0, OPC_NOP, 0, 0, 0, 1'b0);
        #1 checkOutput("gap_fwda", 32'(fwdSelA), 2);
        checkOutput("gap_fwdb", 32'(fwdSelB), 2);
        @(negedge clk);
        idle(3);

        $display("[TB] load-use");
        applyStimulus(1'b1, OPC_LOAD, 5, 1, 7, 1'b0);
        #1 checkOutput("lu_ld_stall", 32'(stall), 0);
        checkOutput("lu_ld_inflight", 32'(inflight), 0);
        @(negedge clk);
        applyStimulus(1'b1, OPC_ALU_RR, 6, 5, 0, 1'b0);
        #1 checkOutput("lu_stall", 32'(stall), 1);
        checkOutput("lu_bubble", 32'(bubbleIdEx), 1);
        checkOutput("lu_inflight1", 32'(inflight), 1);
        @(negedge clk);
        #1 checkOutput("lu_stall_gone", 32'(stall), 0);
        checkOutput("lu_bubble_gone", 32'(bubbleIdEx), 0);
        checkOutput("lu_stallcnt", 32'(stallCnt), 1);
        checkOutput("lu_inflight2", 32'(inflight), 1);
        @(negedge clk);
        applyStimulus(1'b0, OPC_NOP, 0, 0, 0, 1'b0);
        #1 checkOutput("lu_fwda", 32'(fwdSelA), 2);
        checkOutput("lu_fwdb", 32'(fwdSelB), 0);
        checkOutput("lu_inflight3", 32'(inflight), 2);
        @(negedge clk);
        idle(3);

        $display("[TB] jump with hazard");
        applyStimulus(1'b1, OPC_LOAD, 5, 1, 7, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, OPC_ALU_RR, 6, 5, 0, 1'b1);
        #1 checkOutput("jmp_stall", 32'(stall), 0);
        checkOutput("jmp_flush", 32'(flushIfId), 1);
        checkOutput("jmp_bubble", 32'(bubbleIdEx), 1);
        @(negedge clk);
        applyStimulus(1'b0, OPC_NOP, 0, 0, 0, 1'b0);
        #1 checkOutput("jmp_flushcnt", 32'(flushCnt), 1);
        checkOutput("jmp_stallcnt", 32'(stallCnt), 1);
        checkOutput("jmp_inflight", 32'(inflight), 1);
        checkOutput("jmp_fwda", 32'(fwdSelA), 0);
        @(negedge clk);
        idle(3);

        $display("[TB] stall counter saturation");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, OPC_LOAD, 5, 1, 7, 1'b0);
            @(negedge clk);
            applyStimulus(1'b1, OPC_ALU_RR, 6, 5, 0, 1'b0);
            #1 checkOutput("sat_stall", 32'(stall), 1);
            @(negedge clk);
        end
        applyStimulus(1'b0, OPC_NOP, 0, 0, 0, 1'b0);
        #1 checkOutput("sat_stallcnt", 32'(stallCnt), 15);
        checkOutput("sat_flushcnt", 32'(flushCnt), 1);
        @(negedge clk);

        $display("[TB] reset mid-stall");
        applyStimulus(1'b1, OPC_LOAD, 5, 1, 7, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, OPC_ALU_RR, 6, 5, 0, 1'b0);
        #1 checkOutput("mid_stall_pre", 32'(stall), 1);
        #2 rst_n = 1'b0;
        #1 checkOutput("mid_stall", 32'(stall), 0);
        checkOutput("mid_bubble", 32'(bubbleIdEx), 0);
        checkOutput("mid_stallcnt", 32'(stallCnt), 0);
        checkOutput("mid_flushcnt", 32'(flushCnt), 0);
        checkOutput("mid_inflight", 32'(inflight), 0);
        @(negedge clk);
        applyStimulus(1'b0, OPC_NOP, 0, 0, 0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        #1 checkOutput("post_stall", 32'(stall), 0);
        checkOutput("post_inflight", 32'(inflight), 0);
        checkOutput("post_fwda", 32'(fwdSelA), 0);
        checkOutput("post_stallcnt", 32'(stallCnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
